reg_list_reader: RTL



---
 rtl/reg_list_reader_pkg.sv | 21 ++
 rtl/reg_list_priority_enc.sv | 31 +++
 rtl/reg_list_reader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_list_reader_pkg.sv
// Shared definitions for the register-list reader: bank geometry, walker states
// and a small index-to-mask helper.
package reg_list_reader_pkg;

    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic logic [NUM_REGS-1:0] idx_to_bit(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] b;
        b      = '0;
        b[idx] = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/reg_list_priority_enc.sv
// Combinational priority encoder over a register mask: lowest set bit first,
// or highest first when DESCEND is set. Also flags a mask with exactly one bit.
module reg_list_priority_enc
    import reg_list_reader_pkg::*;
#(
    parameter bit DESCEND = 1'b0
) (
    input  logic [NUM_REGS-1:0]  mask,
    output logic                 found,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 one_hot
);

    // The last match written wins, so the scan direction sets the priority.
    always_comb begin
        idx = '0;
        if (DESCEND) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (mask[i]) idx = REG_IDX_W'(i);
            end
        end else begin
            for (int i = NUM_REGS - 1; i >= 0; i--) begin
                if (mask[i]) idx = REG_IDX_W'(i);
            end
        end
    end

    assign found   = |mask;
    assign one_hot = ($countones(mask) == 1);

endmodule

// File: rtl/reg_list_reader.sv
// Walks a 16-bit register list and streams the selected registers out one beat
// per handshake, in ascending (or descending) index order.
module reg_list_reader
    import reg_list_reader_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit DESCEND = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [15:0]          reg_list,
    input  logic                 abort,
    input  logic [DATA_W-1:0]    r0,
    input  logic [DATA_W-1:0]    r1,
    input  logic [DATA_W-1:0]    r2,
    input  logic [DATA_W-1:0]    r3,
    input  logic [DATA_W-1:0]    r4,
    input  logic [DATA_W-1:0]    r5,
    input  logic [DATA_W-1:0]    r6,
    input  logic [DATA_W-1:0]    r7,
    input  logic [DATA_W-1:0]    r8,
    input  logic [DATA_W-1:0]    r9,
    input  logic [DATA_W-1:0]    r10,
    input  logic [DATA_W-1:0]    r11,
    input  logic [DATA_W-1:0]    r12,
    input  logic [DATA_W-1:0]    r13,
    input  logic [DATA_W-1:0]    r14,
    input  logic [DATA_W-1:0]    r15,
    // Beat transfers on a rising edge where out_valid & out_ready; once raised,
    // out_valid and the beat fields stay stable until that edge (or an abort).
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [REG_IDX_W-1:0] out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           count,
    output state_e               dbg_state
);

    state_e                state_q, state_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [REG_IDX_W-1:0]  out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  done_q, done_d;
    logic [4:0]            count_q, count_d;

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0]   enc_mask;
    logic                  enc_found;
    logic                  enc_one_hot;
    logic [REG_IDX_W-1:0]  enc_idx;
    logic [DATA_W-1:0]     sel_data;
    logic                  handshake;

    assign regs[0]  = r0;
    assign regs[1]  = r1;
    assign regs[2]  = r2;
    assign regs[3]  = r3;
    assign regs[4]  = r4;
    assign regs[5]  = r5;
    assign regs[6]  = r6;
    assign regs[7]  = r7;
    assign regs[8]  = r8;
    assign regs[9]  = r9;
    assign regs[10] = r10;
    assign regs[11] = r11;
    assign regs[12] = r12;
    assign regs[13] = r13;
    assign regs[14] = r14;
    assign regs[15] = r15;

    // One encoder serves both the first pick (raw list) and every later pick
    // (pending minus the beat currently held).
    assign enc_mask  = (state_q == IDLE) ? reg_list
                                         : (pending_q & ~idx_to_bit(out_index_q));
    assign sel_data  = regs[enc_idx];
    assign handshake = out_valid_q & out_ready;

    reg_list_priority_enc #(.DESCEND(DESCEND)) u_enc (
        .mask    (enc_mask),
        .found   (enc_found),
        .idx     (enc_idx),
        .one_hot (enc_one_hot)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        count_d     = count_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (reg_list != '0) begin
                        pending_d   = reg_list;
                        out_valid_d = 1'b1;
                        out_data_d  = sel_data;
                        out_index_d = enc_idx;
                        out_last_d  = enc_one_hot;
                        state_d     = EMIT;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    count_d   = count_q + 5'd1;
                    pending_d = enc_mask;
                    if (enc_found) begin
                        out_data_d  = sel_data;
                        out_index_d = enc_idx;
                        out_last_d  = enc_one_hot;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = FINISH;
                        done_d      = 1'b1;
                    end
                end
                // Abort overrides the walk but keeps the count of a coinciding beat.
                if (abort) begin
                    out_valid_d = 1'b0;
                    pending_d   = '0;
                    state_d     = IDLE;
                    done_d      = 1'b0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule
